writeback_register_file: RTL and testbench

WRITEBACK_REGISTER_FILE -- requirements
Module: writeback_register_file

---
 rtl/writeback_register_file.sv | 48 ++++
 tb/tb_writeback_register_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// writeback_register_file: 31 GPRs plus HI/LO with optional same-cycle write-back bypass to the read ports.
module writeback_register_file #(
   parameter bit WRITE_BYPASS = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_register_write_enable,
   input  logic [4:0]  wb_register_write_address,
   input  logic [31:0] wb_register_write_data,
   input  logic        wb_register_hi_write_enable,
   input  logic [31:0] wb_register_hi_write_data,
   input  logic        wb_register_lo_write_enable,
   input  logic [31:0] wb_register_lo_write_data,
   input  logic        read1_enable,
   input  logic [4:0]  read1_address,
   input  logic        read2_enable,
   input  logic [4:0]  read2_address,
   output logic [31:0] read1_data,
   output logic [31:0] read2_data,
   output logic [31:0] hi_read_data,
   output logic [31:0] lo_read_data
);
   logic [31:0] gpr_q [1:31];
   logic [31:0] hi_q, lo_q, hi_d, lo_d;
   logic        gpr_we, byp1, byp2;
   assign gpr_we = wb_register_write_enable && wb_register_write_address != 5'd0;
   assign hi_d = wb_register_hi_write_enable ? wb_register_hi_write_data : hi_q;
   assign lo_d = wb_register_lo_write_enable ? wb_register_lo_write_data : lo_q;
   always_ff @(posedge clock)
      if (reset) begin
         for (int i = 1; i < 32; i++) gpr_q[i] <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (gpr_we) gpr_q[wb_register_write_address] <= wb_register_write_data;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   // Index 0 has no storage, so the zero check must win before the array is consulted.
   assign byp1 = WRITE_BYPASS && gpr_we && read1_address == wb_register_write_address;
   assign byp2 = WRITE_BYPASS && gpr_we && read2_address == wb_register_write_address;
   assign read1_data = (reset || !read1_enable || read1_address == 5'd0) ? '0 :
                       byp1 ? wb_register_write_data : gpr_q[read1_address];
   assign read2_data = (reset || !read2_enable || read2_address == 5'd0) ? '0 :
                       byp2 ? wb_register_write_data : gpr_q[read2_address];
   assign hi_read_data = reset ? '0 : (WRITE_BYPASS && wb_register_hi_write_enable) ? wb_register_hi_write_data : hi_q;
   assign lo_read_data = reset ? '0 : (WRITE_BYPASS && wb_register_lo_write_enable) ? wb_register_lo_write_data : lo_q;
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: directed checks of a bypassing and a non-bypassing register file driven in parallel.
module tb_writeback_register_file;
   logic        clock = 1'b0;
   logic        reset;
   logic        we, hwe, lwe, r1e, r2e;
   logic [4:0]  wa, r1a, r2a;
   logic [31:0] wd, hwd, lwd;
   logic [31:0] r1_b, r2_b, hi_b, lo_b, r1_n, r2_n, hi_n, lo_n;
   int          errors = 0;
   int          checks = 0;

   always #5 clock = ~clock;

   writeback_register_file #(.WRITE_BYPASS(1'b1)) dut_b (
      .clock(clock), .reset(reset),
      .wb_register_write_enable(we), .wb_register_write_address(wa), .wb_register_write_data(wd),
      .wb_register_hi_write_enable(hwe), .wb_register_hi_write_data(hwd),
      .wb_register_lo_write_enable(lwe), .wb_register_lo_write_data(lwd),
      .read1_enable(r1e), .read1_address(r1a), .read2_enable(r2e), .read2_address(r2a),
      .read1_data(r1_b), .read2_data(r2_b), .hi_read_data(hi_b), .lo_read_data(lo_b));

   writeback_register_file #(.WRITE_BYPASS(1'b0)) dut_n (
      .clock(clock), .reset(reset),
      .wb_register_write_enable(we), .wb_register_write_address(wa), .wb_register_write_data(wd),
      .wb_register_hi_write_enable(hwe), .wb_register_hi_write_data(hwd),
      .wb_register_lo_write_enable(lwe), .wb_register_lo_write_data(lwd),
      .read1_enable(r1e), .read1_address(r1a), .read2_enable(r2e), .read2_address(r2a),
      .read1_data(r1_n), .read2_data(r2_n), .hi_read_data(hi_n), .lo_read_data(lo_n));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset = 1'b1;
      {we, hwe, lwe, r1e, r2e} = '0;
      {wa, r1a, r2a} = '0;
      {wd, hwd, lwd} = '0;
      tick();
      tick();
      // Reads and bypass are masked during reset
      we = 1'b1; wa = 5'd5; wd = 32'h1111_2222;
      hwe = 1'b1; hwd = 32'hAAAA_5555; lwe = 1'b1; lwd = 32'h5555_AAAA;
      r1e = 1'b1; r1a = 5'd5; r2e = 1'b1; r2a = 5'd5;
      settle();
      check("rst_r1_b", r1_b, 32'h0);
      check("rst_r2_b", r2_b, 32'h0);
      check("rst_hi_b", hi_b, 32'h0);
      check("rst_lo_b", lo_b, 32'h0);
      tick();
      {we, hwe, lwe} = '0;
      reset = 1'b0;
      settle();
      check("rst_drop_r5", r1_b, 32'h0);
      check("rst_drop_hi", hi_b, 32'h0);
      // r5 write, bypass visible only on the bypassing instance
      we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
      settle();
      check("r5_byp_b", r1_b, 32'h1234_5678);
      check("r5_byp_n", r1_n, 32'h0);
      tick();
      we = 1'b0;
      settle();
      check("r5_r1_b", r1_b, 32'h1234_5678);
      check("r5_r2_b", r2_b, 32'h1234_5678);
      check("r5_r1_n", r1_n, 32'h1234_5678);
      check("r5_r2_n", r2_n, 32'h1234_5678);
      // Write to r0 is discarded
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; r1a = 5'd0;
      settle();
      check("r0_byp_b", r1_b, 32'h0);
      tick();
      we = 1'b0;
      settle();
      check("r0_r1_b", r1_b, 32'h0);
      check("r0_r5_b", r2_b, 32'h1234_5678);
      // Same-cycle write/read of r7
      we = 1'b1; wa = 5'd7; wd = 32'h0000_0001;
      tick();
      wd = 32'hDEAD_BEEF; r1a = 5'd7;
      settle();
      check("r7_same_b", r1_b, 32'hDEAD_BEEF);
      check("r7_same_n", r1_n, 32'h0000_0001);
      tick();
      we = 1'b0;
      settle();
      check("r7_next_b", r1_b, 32'hDEAD_BEEF);
      check("r7_next_n", r1_n, 32'hDEAD_BEEF);
      // HI/LO together, then HI alone
      hwe = 1'b1; hwd = 32'hAAAA_0000; lwe = 1'b1; lwd = 32'h0000_BBBB;
      settle();
      check("hi_byp_b", hi_b, 32'hAAAA_0000);
      check("lo_byp_b", lo_b, 32'h0000_BBBB);
      check("hi_byp_n", hi_n, 32'h0);
      check("lo_byp_n", lo_n, 32'h0);
      tick();
      lwe = 1'b0; hwd = 32'h1111_2222;
      settle();
      check("hi_pair_n", hi_n, 32'hAAAA_0000);
      check("lo_pair_n", lo_n, 32'h0000_BBBB);
      tick();
      hwe = 1'b0;
      settle();
      check("hi_only_b", hi_b, 32'h1111_2222);
      check("lo_kept_b", lo_b, 32'h0000_BBBB);
      check("hi_only_n", hi_n, 32'h1111_2222);
      check("lo_kept_n", lo_n, 32'h0000_BBBB);
      // Disabled port returns zero, other port unaffected
      r1e = 1'b0; r1a = 5'd7; r2a = 5'd7;
      settle();
      check("r1_dis_b", r1_b, 32'h0);
      check("r2_en_b", r2_b, 32'hDEAD_BEEF);
      check("r1_dis_n", r1_n, 32'h0);
      r1e = 1'b1;
      // Load each register with its own index
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; wa = 5'(i); wd = 32'(i);
         tick();
      end
      we = 1'b0; r1a = 5'd3; r2a = 5'd31;
      settle();
      check("load_r3_n", r1_n, 32'd3);
      check("load_r31_n", r2_n, 32'd31);
      check("load_r3_b", r1_b, 32'd3);
      // Mid-stream reset with a pending r3 write
      reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h55;
      settle();
      check("mid_rst_r1_b", r1_b, 32'h0);
      check("mid_rst_r2_n", r2_n, 32'h0);
      tick();
      reset = 1'b0; we = 1'b0;
      settle();
      check("post_rst_r3_b", r1_b, 32'h0);
      check("post_rst_r31_b", r2_b, 32'h0);
      check("post_rst_hi_b", hi_b, 32'h0);
      check("post_rst_lo_n", lo_n, 32'h0);
      for (int i = 1; i < 32; i++) begin
         r1a = 5'(i);
         #1;
         check($sformatf("clr_r%0d_n", i), r1_n, 32'h0);
      end
      // First write after reset commits
      we = 1'b1; wa = 5'd9; wd = 32'hCAFE_F00D; r1a = 5'd9; r2a = 5'd9;
      tick();
      we = 1'b0; wa = 5'd0; wd = 32'h0;
      settle();
      check("first_wr_r1_n", r1_n, 32'hCAFE_F00D);
      check("first_wr_r2_n", r2_n, 32'hCAFE_F00D);
      // Bubble changes nothing
      wa = 5'd9; wd = 32'h0;
      tick();
      settle();
      check("bubble_r9_b", r1_b, 32'hCAFE_F00D);
      check("bubble_hi_b", hi_b, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
